// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand-forwarding unit: EX/ID bypass selects and a load-use bubble FSM.
// Optional macro HFU_PERF_CNT_EN adds a saturating load-use bubble counter on perf_stall_cnt.
module hazard_fwd_unit #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned REG_W      = 5,
    parameter int unsigned LU_BUBBLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*REG_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]       id_rs_valid,
    input  logic [NUM_SRC*REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0]         ex_rd,
    input  logic                     ex_load_regfile,
    input  logic                     ex_is_load,
    input  logic [REG_W-1:0]         mem_rd,
    input  logic                     mem_load_regfile,
    input  logic                     mem_is_load,
    input  logic [REG_W-1:0]         wb_rd,
    input  logic                     wb_load_regfile,
    input  logic                     pipe_stall_ext,
    output logic [2*NUM_SRC-1:0]     ex_fwd_sel,
    output logic [NUM_SRC-1:0]       id_fwd_sel,
    output logic                     hold_id,
    output logic                     bubble_ex,
    output logic                     lu_busy,
    output logic [31:0]              perf_stall_cnt
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_BUBBLE = 1'b1;

    logic [0:0] state;
    logic [1:0] lu_cnt;
    logic       hit;
    logic       in_bubble;

    always_comb begin
        ex_fwd_sel = '0;
        id_fwd_sel = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            // MEM stage holds the younger result, so it wins over WB
            if (mem_load_regfile && (mem_rd != '0) && (mem_rd == ex_rs[i*REG_W +: REG_W]))
                ex_fwd_sel[2*i +: 2] = mem_is_load ? 2'd3 : 2'd1;
            else if (wb_load_regfile && (wb_rd != '0) && (wb_rd == ex_rs[i*REG_W +: REG_W]))
                ex_fwd_sel[2*i +: 2] = 2'd2;
            id_fwd_sel[i] = wb_load_regfile && (wb_rd != '0) && (wb_rd == id_rs[i*REG_W +: REG_W]);
        end
    end

    always_comb begin
        hit = 1'b0;
        if (ex_is_load && ex_load_regfile && (ex_rd != '0)) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (id_rs_valid[i] && (id_rs[i*REG_W +: REG_W] == ex_rd))
                    hit = 1'b1;
            end
        end
    end

    // Reset masks the BUBBLE state immediately so outputs follow RUN rules while rst is high
    assign in_bubble = (state == ST_BUBBLE) && !rst;
    assign hold_id   = in_bubble || hit;
    assign bubble_ex = in_bubble || hit;
    assign lu_busy   = in_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            lu_cnt <= '0;
        end else if (!pipe_stall_ext) begin
            if (state == ST_RUN) begin
                if (hit && (LU_BUBBLES > 1)) begin
                    state  <= ST_BUBBLE;
                    lu_cnt <= 2'(LU_BUBBLES - 1);
                end
            end else begin
                if (lu_cnt == 2'd1) begin
                    state  <= ST_RUN;
                    lu_cnt <= '0;
                end else begin
                    lu_cnt <= lu_cnt - 2'd1;
                end
            end
        end
    end

`ifdef HFU_PERF_CNT_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            perf_cnt <= '0;
        else if (bubble_ex && !pipe_stall_ext && (perf_cnt != '1))
            perf_cnt <= perf_cnt + 32'd1;
    end

    assign perf_stall_cnt = perf_cnt;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule
